tiny_eth_phy_tx: RTL and testbench

TINY_ETH_PHY_TX -- requirements
Module: tiny_eth_phy_tx

---
 rtl/tiny_eth_pkg.sv | 17 +
 rtl/tiny_eth_nibble_fifo.sv | 53 +++++
 rtl/tiny_eth_phy_tx.sv | 189 ++++++++++++++++++
 tb/tb_tiny_eth_phy_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_eth_pkg.sv
// Shared types and constants for the tiny Ethernet serial transmitter.
package tiny_eth_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] PREAMBLE_NIBBLE = 4'b1010;
  localparam logic [NIBBLE_W-1:0] SFD_NIBBLE      = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_IFG
  } tx_state_e;

endpackage

// File: rtl/tiny_eth_nibble_fifo.sv
// Two-entry FIFO of {last, nibble}; ready stays low until the first edge after reset.
module tiny_eth_nibble_fifo
  import tiny_eth_pkg::*;
(
  input  logic              rx_clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [NIBBLE_W:0] i_wdata,
  input  logic              i_pop,
  output logic [NIBBLE_W:0] o_rdata,
  output logic              o_empty,
  output logic              o_ready
);

  logic [NIBBLE_W:0] r_mem [0:1];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;
  logic              r_en;
  logic              w_full;
  logic              w_wr;
  logic              w_rd;

  assign w_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_ready = r_en && !w_full;
  assign w_wr    = i_push && o_ready;
  assign w_rd    = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
      r_en   <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_wr) r_wptr <= ~r_wptr;
      if (w_rd) r_rptr <= ~r_rptr;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/tiny_eth_phy_tx.sv
// Nibble-to-serial Ethernet transmitter: preamble, SFD, data, inter-frame gap.
// Optional TINY_ETH_PHY_TX_UNDERRUN_EN: abort the frame on underrun and drop its remainder.
module tiny_eth_phy_tx
  import tiny_eth_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 14,
  parameter int IFG_BITS         = 96
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic [3:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       line_active,
  output logic       busy
`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
  ,
  output logic       underrun
`endif
);

  localparam logic [7:0]  NIB_LAST = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [11:0] IFG_LAST = 12'(IFG_BITS - 1);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic [3:0]        r_shift;
  logic [3:0]        w_shift_nxt;
  logic [1:0]        r_bit_cnt;
  logic [1:0]        w_bit_cnt_nxt;
  logic [7:0]        r_nib_cnt;
  logic [7:0]        w_nib_cnt_nxt;
  logic [11:0]       r_ifg_cnt;
  logic [11:0]       w_ifg_cnt_nxt;
  logic              r_cur_last;
  logic              w_cur_last_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic              w_empty;
  logic              w_fifo_ready;
  logic              w_boundary;
  logic [NIBBLE_W:0] w_head;

  tiny_eth_nibble_fifo u_fifo (
    .rx_clk  (rx_clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({tx_last, tx_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_ready (w_fifo_ready)
  );

  assign w_accept   = tx_valid && w_fifo_ready;
  assign w_boundary = (r_bit_cnt == 2'd3);

`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
  logic w_uflow;
  logic r_underrun;
  logic r_drop;

  // The nibble arriving on the underrun edge itself already belongs to the dropped tail.
  assign w_push   = w_accept && !(r_drop || w_uflow);
  assign underrun = r_underrun;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_underrun <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_underrun <= w_uflow;
      r_drop     <= (r_drop || w_uflow) && !(w_accept && tx_last);
    end
  end
`else
  assign w_push = w_accept;
`endif

  assign tx_ready    = w_fifo_ready;
  assign serial_out  = r_shift[3];
  assign busy        = (r_state != ST_IDLE);
  assign line_active = (r_state == ST_PREAMBLE) || (r_state == ST_SFD) ||
                       (r_state == ST_DATA);

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = {r_shift[2:0], 1'b0};
    w_bit_cnt_nxt  = r_bit_cnt + 2'd1;
    w_nib_cnt_nxt  = r_nib_cnt;
    w_ifg_cnt_nxt  = r_ifg_cnt;
    w_cur_last_nxt = r_cur_last;
    w_pop          = 1'b0;
`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
    w_uflow        = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_shift_nxt   = '0;
        w_bit_cnt_nxt = '0;
        if (!w_empty) begin
          w_state_nxt   = ST_PREAMBLE;
          w_shift_nxt   = PREAMBLE_NIBBLE;
          w_nib_cnt_nxt = '0;
        end
      end
      ST_PREAMBLE: begin
        if (w_boundary) begin
          if (r_nib_cnt == NIB_LAST) begin
            w_state_nxt = ST_SFD;
            w_shift_nxt = SFD_NIBBLE;
          end else begin
            w_shift_nxt   = PREAMBLE_NIBBLE;
            w_nib_cnt_nxt = r_nib_cnt + 8'd1;
          end
        end
      end
      ST_SFD: begin
        // The nibble that woke the FSM from IDLE is still at the FIFO head.
        if (w_boundary) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_head[NIBBLE_W-1:0];
          w_cur_last_nxt = w_head[NIBBLE_W];
          w_state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_boundary) begin
          if (r_cur_last) begin
            w_state_nxt   = ST_IFG;
            w_shift_nxt   = '0;
            w_ifg_cnt_nxt = '0;
          end else if (!w_empty) begin
            w_pop          = 1'b1;
            w_shift_nxt    = w_head[NIBBLE_W-1:0];
            w_cur_last_nxt = w_head[NIBBLE_W];
          end else begin
`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
            w_uflow       = 1'b1;
            w_state_nxt   = ST_IFG;
            w_shift_nxt   = '0;
            w_ifg_cnt_nxt = '0;
`else
            // Pad with a zero nibble and keep the line up until data returns.
            w_shift_nxt    = '0;
            w_cur_last_nxt = 1'b0;
`endif
          end
        end
      end
      ST_IFG: begin
        w_shift_nxt   = '0;
        w_bit_cnt_nxt = '0;
        if (r_ifg_cnt == IFG_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt + 12'd1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_shift_nxt   = '0;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_nib_cnt  <= '0;
      r_ifg_cnt  <= '0;
      r_cur_last <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_nib_cnt  <= w_nib_cnt_nxt;
      r_ifg_cnt  <= w_ifg_cnt_nxt;
      r_cur_last <= w_cur_last_nxt;
    end
  end

endmodule

// File: tb/tb_tiny_eth_phy_tx.sv
// Directed bench for tiny_eth_phy_tx (PREAMBLE_NIBBLES=2, IFG_BITS=8); serial line logged each cycle.
module tb_tiny_eth_phy_tx;

  localparam int P   = 2;
  localparam int IFG = 8;
  localparam int LOG = 4096;

  logic       rx_clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] tx_data = 4'h0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       serial_out;
  logic       line_active;
  logic       busy;
  logic       underrun;

  int vectors = 0;
  int miscompares = 0;

  logic so_log [0:LOG-1];
  logic la_log [0:LOG-1];
  logic ur_log [0:LOG-1];
  int   n_log = 0;

  tiny_eth_phy_tx #(.PREAMBLE_NIBBLES(P), .IFG_BITS(IFG)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .serial_out  (serial_out),
    .line_active (line_active),
    .busy        (busy)
`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
    ,
    .underrun    (underrun)
`endif
  );

`ifndef TINY_ETH_PHY_TX_UNDERRUN_EN
  assign underrun = 1'b0;
`endif

  always #5 rx_clk = ~rx_clk;

  always @(negedge rx_clk) begin
    if (n_log < LOG) begin
      so_log[n_log] <= serial_out;
      la_log[n_log] <= line_active;
      ur_log[n_log] <= underrun;
      n_log         <= n_log + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int find_la(int from, logic val);
    if (from < 0) return -1;
    for (int i = from; i < n_log; i++) if (la_log[i] === val) return i;
    return -1;
  endfunction

  function automatic logic [63:0] bits_at(int s, int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[62:0], (s + i >= 0 && s + i < n_log) ? so_log[s+i] : 1'bx};
    return v;
  endfunction

  task automatic push(input logic [3:0] d, input logic l, input bit keep);
    int t = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      @(negedge rx_clk);
      t++;
    end
    if (!tx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout tx_ready=%b required 1", tx_ready);
    end
    @(negedge rx_clk);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_rise();
    int t = 0;
    while (!line_active && t < 300) begin
      @(negedge rx_clk);
      t++;
    end
    vectors++;
    if (line_active !== 1'b1) begin
      miscompares++;
      $display("FAIL line_rise_timeout line_active=%b required 1", line_active);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge rx_clk);
    vectors++;
    if ({serial_out, line_active, busy, tx_ready, underrun} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b required 00000",
               {serial_out, line_active, busy, tx_ready, underrun});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge got %b required 0", tx_ready);
    end
    @(negedge rx_clk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_edge got %b required 1", tx_ready);
    end
  endtask

  task automatic test_single_frame();
    int base, s, e;
    base = n_log;
    push(4'hA, 1'b0, 1'b0);
    push(4'h5, 1'b1, 1'b0);
    repeat (40) @(negedge rx_clk);
    s = find_la(base, 1'b1);
    e = find_la(s, 1'b0);
    vectors++;
    if (bits_at(s, 20) !== 64'(20'b1010_1010_1011_1010_0101)) begin
      miscompares++;
      $display("FAIL single_bits got %h required %h", bits_at(s, 20), 20'b1010_1010_1011_1010_0101);
    end
    vectors++;
    if (e - s !== 20) begin
      miscompares++;
      $display("FAIL single_active_len got %0d required 20", e - s);
    end
    vectors++;
    if (bits_at(e, IFG) !== 64'd0 || find_la(e, 1'b1) !== -1) begin
      miscompares++;
      $display("FAIL single_ifg got %h required 0", bits_at(e, IFG));
    end
  endtask

  // Independent receiver: slide over active bits until preamble tail + SFD, then slice nibbles.
  task automatic test_round_trip();
    int base, idx;
    logic [7:0] sh;
    logic [3:0] n0, n1;
    base = n_log;
    push(4'h3, 1'b0, 1'b0);
    push(4'hC, 1'b1, 1'b0);
    repeat (40) @(negedge rx_clk);
    sh  = 8'h00;
    idx = -1;
    for (int i = base; i < n_log && idx < 0; i++) begin
      if (la_log[i] === 1'b1) begin
        sh = {sh[6:0], so_log[i]};
        if (sh == 8'b1010_1011) idx = i + 1;
      end
    end
    n0 = bits_at(idx, 4)[3:0];
    n1 = bits_at(idx + 4, 4)[3:0];
    vectors++;
    if (n0 !== 4'h3) begin
      miscompares++;
      $display("FAIL rt_nibble0 got %h required 3", n0);
    end
    vectors++;
    if (n1 !== 4'hC) begin
      miscompares++;
      $display("FAIL rt_nibble1 got %h required c", n1);
    end
  endtask

  task automatic test_back_to_back();
    int base, s, e, sb, t;
    base = n_log;
    push(4'h9, 1'b0, 1'b0);
    push(4'h6, 1'b1, 1'b0);
    wait_rise();
    t = 0;
    while (line_active && t < 100) begin
      @(negedge rx_clk);
      t++;
    end
    push(4'h1, 1'b1, 1'b0);
    repeat (60) @(negedge rx_clk);
    s  = find_la(base, 1'b1);
    e  = find_la(s, 1'b0);
    sb = find_la(e, 1'b1);
    vectors++;
    if (bits_at(s, 20) !== 64'(20'b1010_1010_1011_1001_0110)) begin
      miscompares++;
      $display("FAIL b2b_frame_a got %h required %h", bits_at(s, 20), 20'b1010_1010_1011_1001_0110);
    end
    // Idle span between frames: IFG_BITS gap cycles plus the single IDLE cycle.
    vectors++;
    if (sb - e !== IFG + 1) begin
      miscompares++;
      $display("FAIL b2b_gap got %0d required %0d", sb - e, IFG + 1);
    end
    vectors++;
    if (bits_at(sb, 16) !== 64'(16'b1010_1010_1011_0001)) begin
      miscompares++;
      $display("FAIL b2b_frame_b got %h required %h", bits_at(sb, 16), 16'b1010_1010_1011_0001);
    end
  endtask

  task automatic test_backpressure();
    int base, s, e;
    logic rdy_full;
    base     = n_log;
    rdy_full = 1'bx;
    for (int k = 0; k < 6; k++) begin
      push(4'(k + 1), (k == 5), (k != 5));
      if (k == 1) rdy_full = tx_ready;
    end
    repeat (80) @(negedge rx_clk);
    vectors++;
    if (rdy_full !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready_when_full got %b required 0", rdy_full);
    end
    s = find_la(base, 1'b1);
    e = find_la(s, 1'b0);
    vectors++;
    if (bits_at(s + 4 * P + 4, 24) !== 64'h123456) begin
      miscompares++;
      $display("FAIL bp_data got %h required 123456", bits_at(s + 4 * P + 4, 24));
    end
    vectors++;
    if (e - s !== 36) begin
      miscompares++;
      $display("FAIL bp_active_len got %0d required 36", e - s);
    end
  endtask

  task automatic test_underrun();
    int base, s, e, sb, ones, where;
    base = n_log;
    push(4'hF, 1'b0, 1'b0);
    wait_rise();
    repeat (17) @(negedge rx_clk);
`ifdef TINY_ETH_PHY_TX_UNDERRUN_EN
    push(4'h2, 1'b0, 1'b0);
    push(4'h8, 1'b1, 1'b0);
    repeat (20) @(negedge rx_clk);
    push(4'h5, 1'b1, 1'b0);
    repeat (50) @(negedge rx_clk);
    s  = find_la(base, 1'b1);
    e  = find_la(s, 1'b0);
    sb = find_la(e, 1'b1);
    ones  = 0;
    where = -1;
    for (int i = base; i < n_log; i++) if (ur_log[i] === 1'b1) begin ones++; where = i; end
    vectors++;
    if (bits_at(s, 16) !== 64'(16'b1010_1010_1011_1111) || e - s !== 16) begin
      miscompares++;
      $display("FAIL ur_aborted_frame got %h len %0d required %h len 16",
               bits_at(s, 16), e - s, 16'b1010_1010_1011_1111);
    end
    vectors++;
    if (ones !== 1 || where !== s + 16) begin
      miscompares++;
      $display("FAIL ur_pulse got count %0d at %0d required count 1 at %0d", ones, where, s + 16);
    end
    vectors++;
    if (bits_at(sb, 16) !== 64'(16'b1010_1010_1011_0101) || find_la(sb, 1'b0) - sb !== 16) begin
      miscompares++;
      $display("FAIL ur_next_frame got %h required %h", bits_at(sb, 16), 16'b1010_1010_1011_0101);
    end
`else
    push(4'h8, 1'b1, 1'b0);
    repeat (50) @(negedge rx_clk);
    s = find_la(base, 1'b1);
    e = find_la(s, 1'b0);
    vectors++;
    if (bits_at(s, 24) !== 64'(24'b1010_1010_1011_1111_0000_1000)) begin
      miscompares++;
      $display("FAIL ur_pad_bits got %h required %h", bits_at(s, 24), 24'b1010_1010_1011_1111_0000_1000);
    end
    vectors++;
    if (e - s !== 24) begin
      miscompares++;
      $display("FAIL ur_pad_active_len got %0d required 24", e - s);
    end
`endif
  endtask

  task automatic test_reset_mid_data();
    int base, s, e, sb, ones;
    base = n_log;
    push(4'hC, 1'b0, 1'b0);
    push(4'h3, 1'b1, 1'b0);
    wait_rise();
    repeat (13) @(negedge rx_clk);
    vectors++;
    if (serial_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre_bit got %b required 1", serial_out);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({serial_out, line_active, busy, tx_ready} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got %b required 0000", {serial_out, line_active, busy, tx_ready});
    end
    @(negedge rx_clk);
    rst = 1'b1;
    repeat (3) @(negedge rx_clk);
    push(4'h7, 1'b1, 1'b0);
    repeat (40) @(negedge rx_clk);
    s  = find_la(base, 1'b1);
    e  = find_la(s, 1'b0);
    sb = find_la(e, 1'b1);
    ones = 0;
    for (int i = e; i < sb; i++) if (so_log[i] !== 1'b0) ones++;
    vectors++;
    if (e - s !== 14 || ones !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_abandon got len %0d tail %0d required len 14 tail 0", e - s, ones);
    end
    vectors++;
    if (bits_at(sb, 16) !== 64'(16'b1010_1010_1011_0111)) begin
      miscompares++;
      $display("FAIL rst_mid_next_frame got %h required %h", bits_at(sb, 16), 16'b1010_1010_1011_0111);
    end
  endtask

  task automatic test_line_idle_level();
    int bad = 0;
    for (int i = 0; i < n_log; i++) if (la_log[i] === 1'b0 && so_log[i] !== 1'b0) bad++;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL idle_line_level got %0d high samples required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_trip();
    test_back_to_back();
    test_backpressure();
    test_underrun();
    test_reset_mid_data();
    repeat (2) @(negedge rx_clk);
    test_line_idle_level();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
